// File: rtl/noc_inject_scheduler_pkg.sv
// Shared NoC types (stand-in for the platform rvh_noc_pkg) and scheduler sizing helpers.
package rvh_noc_pkg;
  localparam int FLIT_LENGTH     = 32;
  localparam int VC_ID_NUM_MAX_W = 3;
  typedef logic [2:0] io_port_t;
endpackage

package noc_inject_scheduler_pkg;
  // Bits needed to hold 0..max_val inclusive, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index n entries, never less than one.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/noc_inject_scheduler_if.sv
// Local requester bus plus the flit/credit link towards the router local input port.
interface noc_inject_scheduler_if
  import rvh_noc_pkg::*;
#(
  parameter int  REQ_NUM        = 4,
  parameter int  VC_NUM         = 4,
  parameter type flit_payload_t = logic [FLIT_LENGTH-1:0]
);
  logic [REQ_NUM-1:0]         req_v_i;
  flit_payload_t              req_flit_i               [REQ_NUM];
  logic [VC_ID_NUM_MAX_W-1:0] req_vc_id_i              [REQ_NUM];
  io_port_t                   req_look_ahead_routing_i [REQ_NUM];
  logic [REQ_NUM-1:0]         req_rdy_o;

  logic                       tx_flit_v_o;
  flit_payload_t              tx_flit_o;
  io_port_t                   tx_flit_vc_id_o;
  io_port_t                   tx_flit_look_ahead_routing_o;
  logic                       tx_flit_pend_o;

  logic                       tx_lcrd_v_i;
  logic [VC_ID_NUM_MAX_W-1:0] tx_lcrd_id_i;

  logic [VC_NUM-1:0]          credit_avail_o;
  logic                       err_o;

  modport master (
    output req_v_i, req_flit_i, req_vc_id_i, req_look_ahead_routing_i,
    output tx_lcrd_v_i, tx_lcrd_id_i,
    input  req_rdy_o, tx_flit_v_o, tx_flit_o, tx_flit_vc_id_o,
    input  tx_flit_look_ahead_routing_o, tx_flit_pend_o, credit_avail_o, err_o
  );

  modport slave (
    input  req_v_i, req_flit_i, req_vc_id_i, req_look_ahead_routing_i,
    input  tx_lcrd_v_i, tx_lcrd_id_i,
    output req_rdy_o, tx_flit_v_o, tx_flit_o, tx_flit_vc_id_o,
    output tx_flit_look_ahead_routing_o, tx_flit_pend_o, credit_avail_o, err_o
  );
endinterface

// File: rtl/noc_inject_scheduler_arb.sv
// Round-robin arbiter: grants the first request at or above the pointer, pointer moves past the winner.
module noc_rr_arbiter
  import noc_inject_scheduler_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  output logic [N-1:0]          grant,
  output logic                  grant_v,
  output logic [idx_w(N)-1:0]   grant_idx
);
  localparam int IW = idx_w(N);

  logic [IW-1:0] ptr_r;

  // Scan offsets from far to near so the nearest requester at or above ptr_r wins.
  always_comb begin : p_pick
    int cand;
    cand      = 0;
    grant     = '0;
    grant_idx = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand      = (int'(ptr_r) + off) % N;
      grant     = req[cand] ? (N'(1) << cand) : grant;
      grant_idx = req[cand] ? IW'(cand) : grant_idx;
    end
    grant_v = |req;
  end

  // Pointer advances only on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (grant_v) begin
      ptr_r <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
endmodule

// File: rtl/noc_inject_scheduler.sv
// Credit-based injection scheduler: arbitrates local requesters onto one router input port.
module noc_inject_scheduler
  import rvh_noc_pkg::*;
  import noc_inject_scheduler_pkg::*;
#(
  parameter int  REQ_NUM        = 4,
  parameter int  VC_NUM         = 4,
  parameter int  VC_DEPTH       = 2,
  parameter type flit_payload_t = logic [FLIT_LENGTH-1:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  noc_inject_scheduler_if.slave  bus
);
  localparam int                         CRD_W    = cnt_w(VC_DEPTH);
  localparam int                         IDX_W    = idx_w(REQ_NUM);
  localparam logic [CRD_W-1:0]           CRD_FULL = CRD_W'(VC_DEPTH);
  localparam logic [VC_ID_NUM_MAX_W:0]   VC_LIMIT = (VC_ID_NUM_MAX_W + 1)'(VC_NUM);

  logic [CRD_W-1:0]   credit_r [VC_NUM];
  logic [REQ_NUM-1:0] vc_ok_s;
  logic [REQ_NUM-1:0] elig_s;
  logic [REQ_NUM-1:0] grant_s;
  logic               gnt_v_s;
  logic [IDX_W-1:0]   gnt_idx_s;
  logic [VC_NUM-1:0]  send_s;
  logic [VC_NUM-1:0]  ret_s;
  logic [VC_NUM-1:0]  ovf_s;
  logic [VC_NUM-1:0]  crd_avail_s;
  logic               err_next_s;

  logic               tx_v_r;
  flit_payload_t      tx_flit_r;
  io_port_t           tx_vc_r;
  io_port_t           tx_la_r;
  logic               pend_r;
  logic               err_r;

  // Eligibility: valid, in-range VC with a non-zero credit; nothing is eligible during reset.
  always_comb begin
    for (int i = 0; i < REQ_NUM; i++) begin
      vc_ok_s[i] = ({1'b0, bus.req_vc_id_i[i]} < VC_LIMIT);
      elig_s[i]  = 1'b0;
      for (int v = 0; v < VC_NUM; v++) begin
        elig_s[i] = elig_s[i] |
                    ((bus.req_vc_id_i[i] == VC_ID_NUM_MAX_W'(v)) && (credit_r[v] != '0));
      end
      elig_s[i] = elig_s[i] & bus.req_v_i[i] & vc_ok_s[i] & ~rst;
    end
  end

  noc_rr_arbiter #(.N(REQ_NUM)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (elig_s),
    .grant     (grant_s),
    .grant_v   (gnt_v_s),
    .grant_idx (gnt_idx_s)
  );

  // Per-VC send/return decode and protocol error detection.
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      send_s[v]      = gnt_v_s & (bus.req_vc_id_i[gnt_idx_s] == VC_ID_NUM_MAX_W'(v));
      ret_s[v]       = bus.tx_lcrd_v_i & (bus.tx_lcrd_id_i == VC_ID_NUM_MAX_W'(v));
      ovf_s[v]       = ret_s[v] & ~send_s[v] & (credit_r[v] == CRD_FULL);
      crd_avail_s[v] = (credit_r[v] != '0);
    end
    err_next_s = err_r | (|ovf_s)
               | (bus.tx_lcrd_v_i & ({1'b0, bus.tx_lcrd_id_i} >= VC_LIMIT))
               | (|(bus.req_v_i & ~vc_ok_s));
  end

  // Credit counters; a return that would exceed VC_DEPTH saturates instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) credit_r[v] <= CRD_FULL;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (send_s[v] && !ret_s[v]) begin
          credit_r[v] <= credit_r[v] - CRD_W'(1);
        end else if (ret_s[v] && !send_s[v] && !ovf_s[v]) begin
          credit_r[v] <= credit_r[v] + CRD_W'(1);
        end else begin
          credit_r[v] <= credit_r[v];
        end
      end
    end
  end

  // Registered tx stage, pending flag and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_v_r    <= 1'b0;
      tx_flit_r <= '0;
      tx_vc_r   <= '0;
      tx_la_r   <= '0;
      pend_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      tx_v_r <= gnt_v_s;
      pend_r <= |bus.req_v_i;
      err_r  <= err_next_s;
      if (gnt_v_s) begin
        tx_flit_r <= bus.req_flit_i[gnt_idx_s];
        tx_vc_r   <= io_port_t'(bus.req_vc_id_i[gnt_idx_s]);
        tx_la_r   <= bus.req_look_ahead_routing_i[gnt_idx_s];
      end else begin
        tx_flit_r <= tx_flit_r;
        tx_vc_r   <= tx_vc_r;
        tx_la_r   <= tx_la_r;
      end
    end
  end

  assign bus.req_rdy_o                    = grant_s;
  assign bus.tx_flit_v_o                  = tx_v_r;
  assign bus.tx_flit_o                    = tx_flit_r;
  assign bus.tx_flit_vc_id_o              = tx_vc_r;
  assign bus.tx_flit_look_ahead_routing_o = tx_la_r;
  assign bus.tx_flit_pend_o               = pend_r;
  assign bus.credit_avail_o               = crd_avail_s;
  assign bus.err_o                        = err_r;
endmodule

// File: tb/tb_noc_inject_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a credit/round-robin model.
module tb_noc_inject_scheduler;
  import rvh_noc_pkg::*;

  localparam int RN = 4;
  localparam int VN = 4;
  localparam int VD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_inject_scheduler_if #(.REQ_NUM(RN), .VC_NUM(VN)) bus ();
  noc_inject_scheduler #(.REQ_NUM(RN), .VC_NUM(VN), .VC_DEPTH(VD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  int                     m_credit [VN];
  int                     m_rr;
  bit                     m_err;
  bit                     m_txv;
  bit                     m_pend;
  logic [FLIT_LENGTH-1:0] m_flit;
  io_port_t               m_vc;
  io_port_t               m_la;

  task automatic model_reset();
    for (int v = 0; v < VN; v++) m_credit[v] = VD;
    m_rr = 0; m_err = 0; m_txv = 0; m_pend = 0;
    m_flit = '0; m_vc = '0; m_la = '0;
  endtask

  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < RN; k++) begin
      int i  = (m_rr + k) % RN;
      int vc = int'(bus.req_vc_id_i[i]);
      if (bus.req_v_i[i] && vc < VN) begin
        if (m_credit[vc] > 0) return i;
      end
    end
    return -1;
  endfunction

  function automatic logic [RN-1:0] model_rdy();
    int g = model_grant();
    return (g < 0) ? 4'b0000 : (4'b0001 << g);
  endfunction

  function automatic logic [VN-1:0] model_avail();
    logic [VN-1:0] a;
    for (int v = 0; v < VN; v++) a[v] = (m_credit[v] > 0);
    return a;
  endfunction

  task automatic model_edge();
    int g = model_grant();
    int sent_vc = -1;
    if (g >= 0) begin
      sent_vc = int'(bus.req_vc_id_i[g]);
      m_credit[sent_vc]--;
      m_rr   = (g + 1) % RN;
      m_txv  = 1;
      m_flit = bus.req_flit_i[g];
      m_vc   = io_port_t'(bus.req_vc_id_i[g]);
      m_la   = bus.req_look_ahead_routing_i[g];
    end else begin
      m_txv = 0;
    end
    for (int i = 0; i < RN; i++)
      if (bus.req_v_i[i] && int'(bus.req_vc_id_i[i]) >= VN) m_err = 1;
    if (bus.tx_lcrd_v_i) begin
      int id = int'(bus.tx_lcrd_id_i);
      if (id >= VN) m_err = 1;
      else if (id == sent_vc) m_credit[id]++;
      else if (m_credit[id] == VD) m_err = 1;
      else m_credit[id]++;
    end
    m_pend = |bus.req_v_i;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_v_i      = '0;
    bus.tx_lcrd_v_i  = 1'b0;
    bus.tx_lcrd_id_i = '0;
    for (int i = 0; i < RN; i++) begin
      bus.req_flit_i[i]               = '0;
      bus.req_vc_id_i[i]              = '0;
      bus.req_look_ahead_routing_i[i] = '0;
    end
  endtask

  task automatic set_req(input int i, input int vc);
    bus.req_v_i[i]                  = 1'b1;
    bus.req_vc_id_i[i]              = VC_ID_NUM_MAX_W'(vc);
    bus.req_flit_i[i]               = $urandom;
    bus.req_look_ahead_routing_i[i] = io_port_t'($urandom_range(0, 4));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    bus.req_v_i = 4'b1111;
    #1;
    checks++; if (bus.req_rdy_o !== 4'b0000) begin errors++; $display("FAIL reset_rdy: got %b expected 0000", bus.req_rdy_o); end
    @(posedge clk); #1;
    checks++; if (bus.tx_flit_v_o !== 1'b0) begin errors++; $display("FAIL reset_txv: got %b expected 0", bus.tx_flit_v_o); end
    checks++; if (bus.tx_flit_o !== 32'h0 || bus.tx_flit_vc_id_o !== 3'd0 || bus.tx_flit_look_ahead_routing_o !== 3'd0) begin
      errors++; $display("FAIL reset_txfields: got %h/%0d/%0d expected 0/0/0", bus.tx_flit_o, bus.tx_flit_vc_id_o, bus.tx_flit_look_ahead_routing_o); end
    checks++; if (bus.tx_flit_pend_o !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b expected 0", bus.tx_flit_pend_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err_o); end
    checks++; if (bus.credit_avail_o !== 4'hf) begin errors++; $display("FAIL reset_avail: got %b expected 1111", bus.credit_avail_o); end
    clear_inputs();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single_vc_drain();
    logic [RN-1:0] exp_rdy [3];
    exp_rdy[0] = 4'b0001; exp_rdy[1] = 4'b0001; exp_rdy[2] = 4'b0000;
    do_reset();
    set_req(0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.req_rdy_o !== exp_rdy[c]) begin errors++; $display("FAIL drain_rdy c%0d: got %b expected %b", c, bus.req_rdy_o, exp_rdy[c]); end
      tick();
      checks++; if (bus.tx_flit_v_o !== m_txv) begin errors++; $display("FAIL drain_txv c%0d: got %b expected %b", c, bus.tx_flit_v_o, m_txv); end
      bus.req_flit_i[0] = $urandom;
    end
    checks++; if (bus.credit_avail_o[0] !== 1'b0) begin errors++; $display("FAIL drain_avail: got %b expected 0", bus.credit_avail_o[0]); end
    checks++; if (bus.tx_flit_pend_o !== 1'b1) begin errors++; $display("FAIL drain_pend: got %b expected 1", bus.tx_flit_pend_o); end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int order [5];
    logic [FLIT_LENGTH-1:0] exp_flit;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    do_reset();
    for (int i = 0; i < RN; i++) set_req(i, i);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.req_rdy_o !== (4'b0001 << order[c])) begin errors++; $display("FAIL rr_rdy c%0d: got %b expected %b", c, bus.req_rdy_o, 4'b0001 << order[c]); end
      exp_flit = bus.req_flit_i[order[c]];
      tick();
      checks++; if (bus.tx_flit_v_o !== 1'b1 || bus.tx_flit_o !== exp_flit || bus.tx_flit_vc_id_o !== io_port_t'(order[c])) begin
        errors++; $display("FAIL rr_tx c%0d: got v%b %h vc%0d expected v1 %h vc%0d", c, bus.tx_flit_v_o, bus.tx_flit_o, bus.tx_flit_vc_id_o, exp_flit, order[c]); end
    end
    clear_inputs();
  endtask

  task automatic test_credit_return_latency();
    do_reset();
    set_req(1, 1);
    tick(); tick();
    bus.tx_lcrd_v_i  = 1'b1;
    bus.tx_lcrd_id_i = 3'd1;
    #1;
    checks++; if (bus.req_rdy_o !== 4'b0000) begin errors++; $display("FAIL ret_rdy_t: got %b expected 0000", bus.req_rdy_o); end
    tick();
    bus.tx_lcrd_v_i = 1'b0;
    #1;
    checks++; if (bus.req_rdy_o !== 4'b0010) begin errors++; $display("FAIL ret_rdy_t1: got %b expected 0010", bus.req_rdy_o); end
    checks++; if (bus.tx_flit_v_o !== 1'b0) begin errors++; $display("FAIL ret_txv_t1: got %b expected 0", bus.tx_flit_v_o); end
    tick();
    checks++; if (bus.tx_flit_v_o !== 1'b1 || bus.tx_flit_vc_id_o !== 3'd1) begin errors++; $display("FAIL ret_txv_t2: got v%b vc%0d expected v1 vc1", bus.tx_flit_v_o, bus.tx_flit_vc_id_o); end
    clear_inputs();
  endtask

  task automatic test_same_cycle_send_return();
    do_reset();
    set_req(2, 2);
    tick();
    bus.tx_lcrd_v_i  = 1'b1;
    bus.tx_lcrd_id_i = 3'd2;
    #1;
    checks++; if (bus.req_rdy_o !== 4'b0100) begin errors++; $display("FAIL same_rdy: got %b expected 0100", bus.req_rdy_o); end
    tick();
    bus.tx_lcrd_v_i = 1'b0;
    #1;
    checks++; if (bus.credit_avail_o[2] !== 1'b1 || bus.err_o !== 1'b0) begin errors++; $display("FAIL same_credit: got avail%b err%b expected avail1 err0", bus.credit_avail_o[2], bus.err_o); end
    tick();
    checks++; if (bus.credit_avail_o[2] !== 1'b0) begin errors++; $display("FAIL same_credit_one: got %b expected 0", bus.credit_avail_o[2]); end
    clear_inputs();
  endtask

  task automatic test_errors();
    do_reset();
    bus.tx_lcrd_v_i  = 1'b1;
    bus.tx_lcrd_id_i = 3'd3;
    tick();
    bus.tx_lcrd_v_i = 1'b0;
    checks++; if (bus.credit_avail_o !== 4'hf || bus.err_o !== 1'b1) begin errors++; $display("FAIL ovf: got avail%b err%b expected avail1111 err1", bus.credit_avail_o, bus.err_o); end
    tick(); tick(); tick();
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus.err_o); end
    set_req(3, 3); tick(); tick(); clear_inputs();
    checks++; if (bus.credit_avail_o[3] !== 1'b0) begin errors++; $display("FAIL ovf_saturate: got %b expected 0", bus.credit_avail_o[3]); end
    do_reset();
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", bus.err_o); end
    bus.tx_lcrd_v_i  = 1'b1;
    bus.tx_lcrd_id_i = 3'd5;
    tick();
    bus.tx_lcrd_v_i = 1'b0;
    checks++; if (bus.err_o !== 1'b1 || bus.credit_avail_o !== 4'hf) begin errors++; $display("FAIL bad_ret_id: got err%b avail%b expected err1 avail1111", bus.err_o, bus.credit_avail_o); end
    do_reset();
    set_req(0, 5);
    #1;
    checks++; if (bus.req_rdy_o !== 4'b0000) begin errors++; $display("FAIL bad_vc_rdy: got %b expected 0000", bus.req_rdy_o); end
    tick();
    checks++; if (bus.err_o !== 1'b1 || bus.tx_flit_v_o !== 1'b0) begin errors++; $display("FAIL bad_vc_err: got err%b txv%b expected err1 txv0", bus.err_o, bus.tx_flit_v_o); end
    clear_inputs();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_req(0, 0);
    tick();
    checks++; if (bus.tx_flit_v_o !== 1'b1) begin errors++; $display("FAIL mid_txv_pre: got %b expected 1", bus.tx_flit_v_o); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.tx_flit_v_o !== 1'b0 || bus.req_rdy_o !== 4'b0000) begin errors++; $display("FAIL mid_async: got txv%b rdy%b expected txv0 rdy0000", bus.tx_flit_v_o, bus.req_rdy_o); end
    model_reset();
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.credit_avail_o !== 4'hf) begin errors++; $display("FAIL mid_avail: got %b expected 1111", bus.credit_avail_o); end
    set_req(0, 0);
    for (int c = 0; c <= VD; c++) begin
      #1;
      checks++; if (bus.req_rdy_o !== ((c < VD) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL mid_depth c%0d: got %b", c, bus.req_rdy_o); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_random_traffic();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < RN; i++) begin
        bus.req_v_i[i]                  = ($urandom_range(0, 2) != 0);
        bus.req_vc_id_i[i]              = ($urandom_range(0, 99) == 0) ? 3'd6 : VC_ID_NUM_MAX_W'($urandom_range(0, VN - 1));
        bus.req_flit_i[i]               = $urandom;
        bus.req_look_ahead_routing_i[i] = io_port_t'($urandom_range(0, 4));
      end
      bus.tx_lcrd_v_i  = 1'b0;
      bus.tx_lcrd_id_i = VC_ID_NUM_MAX_W'($urandom_range(0, VN - 1));
      if ($urandom_range(0, 1) == 1) begin
        int v = int'(bus.tx_lcrd_id_i);
        bus.tx_lcrd_v_i = (m_credit[v] < VD) || ($urandom_range(0, 49) == 0);
      end
      #1;
      checks++; if (bus.req_rdy_o !== model_rdy()) begin errors++; $display("FAIL rand_rdy n%0d: got %b expected %b", n, bus.req_rdy_o, model_rdy()); end
      tick();
      checks++; if (bus.tx_flit_v_o !== m_txv || bus.tx_flit_o !== m_flit || bus.tx_flit_vc_id_o !== m_vc || bus.tx_flit_look_ahead_routing_o !== m_la) begin
        errors++; $display("FAIL rand_tx n%0d: got v%b %h vc%0d la%0d expected v%b %h vc%0d la%0d", n, bus.tx_flit_v_o, bus.tx_flit_o,
                           bus.tx_flit_vc_id_o, bus.tx_flit_look_ahead_routing_o, m_txv, m_flit, m_vc, m_la); end
      checks++; if (bus.credit_avail_o !== model_avail() || bus.tx_flit_pend_o !== m_pend || bus.err_o !== m_err) begin
        errors++; $display("FAIL rand_state n%0d: got avail%b pend%b err%b expected avail%b pend%b err%b", n, bus.credit_avail_o,
                           bus.tx_flit_pend_o, bus.err_o, model_avail(), m_pend, m_err); end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_vc_drain();
    test_round_robin();
    test_credit_return_latency();
    test_same_cycle_send_return();
    test_errors();
    test_reset_midflight();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_inject_scheduler.md
NOC_INJECT_SCHEDULER -- requirements
Module: noc_inject_scheduler

Interface
REQ-001 Parameter REQ_NUM, default 4: number of local requesters sharing the router local input port.
REQ-002 Parameter VC_NUM, default 4: VCs on the router local input port.
REQ-003 Parameter VC_DEPTH, default 2: flit slots per VC and initial credit per VC.
REQ-004 Parameter flit_payload_t, default logic[FLIT_LENGTH-1:0]: flit payload type.
REQ-005 clk  input  1: single clock; all state updates on rising edge.
REQ-006 rst  input  1: reset, asynchronous and active-high.
REQ-007 req_v_i  input  REQ_NUM: requester i holds a flit.
REQ-008 req_flit_i  input  REQ_NUM x flit_payload_t: per-requester payload.
REQ-009 req_vc_id_i  input  REQ_NUM x VC_ID_NUM_MAX_W: target VC per requester.
REQ-010 req_look_ahead_routing_i  input  REQ_NUM x io_port_t: look-ahead output port.
REQ-011 req_rdy_o  output  REQ_NUM: one-hot grant; transfer when req_v_i[i] and req_rdy_o[i] are both high.
REQ-012 tx_flit_v_o / tx_flit_o / tx_flit_vc_id_o / tx_flit_look_ahead_routing_o  output  1 / flit_payload_t / io_port_t / io_port_t: registered flit to router rx port.
REQ-013 tx_flit_pend_o  output  1: registered OR of req_v_i.
REQ-014 tx_lcrd_v_i  input  1; tx_lcrd_id_i  input  VC_ID_NUM_MAX_W: credit return from router rx_lcrd_v_o/rx_lcrd_id_o.
REQ-015 credit_avail_o  output  VC_NUM: bit v high when credit[v] != 0.
REQ-016 err_o  output  1: sticky protocol error flag.

Function
REQ-017 Per-VC credit counter, width $clog2(VC_DEPTH+1), shall hold VC_DEPTH after reset.
REQ-018 Requester i eligible when req_v_i[i] and req_vc_id_i[i] < VC_NUM and credit[req_vc_id_i[i]] != 0.
REQ-019 Round-robin: grant the first eligible index at or above rr_ptr, wrapping modulo REQ_NUM; at most one grant per cycle.
REQ-020 req_rdy_o shall be combinational from current-cycle inputs and state; no grant when no requester eligible.
REQ-021 rr_ptr shall reset to 0 and update to (granted index + 1) mod REQ_NUM only on a grant; otherwise hold.
REQ-022 On grant, tx_flit_* shall be loaded with the granted requester's fields and tx_flit_v_o asserted the next cycle (latency 1); without grant tx_flit_v_o = 0 next cycle, other tx fields hold.
REQ-023 credit[v] next = credit[v] - (grant to VC v) + (tx_lcrd_v_i and tx_lcrd_id_i == v); simultaneous send and return on the same VC leaves it unchanged.
REQ-024 Credit return on a VC at VC_DEPTH with no concurrent send: counter saturates at VC_DEPTH, err_o set.
REQ-025 tx_lcrd_id_i >= VC_NUM with tx_lcrd_v_i high: return ignored, err_o set.
REQ-026 req_vc_id_i[i] >= VC_NUM: requester never granted, err_o set while req_v_i[i] high.
REQ-027 err_o stays set until reset.
REQ-028 A credit returned in cycle t is usable for a grant in cycle t+1, not t.

Reset
REQ-029 On rst: credits = VC_DEPTH, rr_ptr = 0, tx_flit_v_o = 0, tx_flit_o/vc_id/look_ahead = 0, tx_flit_pend_o = 0, err_o = 0.
REQ-030 Reset mid-transfer shall drop any in-flight tx_flit_v_o immediately (asynchronously); no partial credit state survives.
REQ-031 req_rdy_o shall be 0 while rst is high.

Structure
REQ-032 VC_ID_NUM_MAX_W, io_port_t, FLIT_LENGTH come from rvh_noc_pkg; no new package types.
REQ-033 One sub-module, noc_rr_arbiter (parameterised N, req/grant/pointer-update), shall implement REQ-019/REQ-021.

Verification
REQ-034 After reset, req_v_i=4'b0001, vc 0, three back-to-back cycles, no returns -> two grants, third cycle req_rdy_o=0, credit_avail_o[0]=0.
REQ-035 req_v_i=4'b1111, all to distinct VCs, credits full -> grants in order 0,1,2,3,0 over five cycles.
REQ-036 credit[1]=0, send blocked; tx_lcrd_v_i=1, id=1 in cycle t -> grant to VC 1 in t+1, tx_flit_v_o in t+2.
REQ-037 credit[2]=1, grant to VC 2 and return on VC 2 same cycle -> credit[2] stays 1, err_o=0.
REQ-038 Return on VC 3 at credit 2 (VC_DEPTH) -> credit stays 2, err_o=1 until rst; tx_lcrd_id_i=5 -> err_o=1.
REQ-039 Assert rst while tx_flit_v_o=1 -> tx_flit_v_o=0 without clock edge, all credits read back VC_DEPTH after release.
